// File: rtl/kb_note_sequencer.sv
// kb_note_sequencer: PS/2 set-2 scan-code parser, 12-key note mapper with octave control,
// typematic suppression and a note-event FIFO. Optional KB_OCT_WRAP_EN makes octave stepping wrap.
`default_nettype none

module kb_note_sequencer #(
    parameter logic [7:0] OCT_UP_CODE = 8'h55,
    parameter logic [7:0] OCT_DN_CODE = 8'h4E,
    parameter logic [2:0] OCT_RESET   = 3'd4,
    parameter logic [2:0] OCT_MAX     = 3'd7,
    parameter int         EVT_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  scan_code,
    input  logic        scan_valid,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_note,
    output logic [2:0]  evt_octave,
    output logic        evt_on,
    output logic [2:0]  octave,
    output logic [11:0] held_mask,
    output logic        evt_overflow
);

    localparam int AW = $clog2(EVT_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BRK     = 2'd1;
    localparam logic [1:0] S_EXT     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    logic [1:0]  r_state, w_state_next;
    logic        w_do_make, w_do_break;
    logic [3:0]  w_note, w_idx;
    logic [2:0]  w_oct_up, w_oct_dn;
    logic [2:0]  r_note_oct [0:11];
    logic        r_push;
    logic [7:0]  r_push_data;
    logic [7:0]  r_mem [0:EVT_DEPTH-1];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, w_count_next;
    logic        w_pop, w_full, w_wr;

    // Z S X D C F V B H N J M  ->  F F# G G# A A# B C C# D D# E
    function automatic logic [3:0] key_note(input logic [7:0] code);
        case (code)
            8'h1A: key_note = 4'd1;
            8'h1B: key_note = 4'd2;
            8'h22: key_note = 4'd3;
            8'h23: key_note = 4'd4;
            8'h21: key_note = 4'd5;
            8'h2B: key_note = 4'd6;
            8'h2A: key_note = 4'd7;
            8'h32: key_note = 4'd8;
            8'h33: key_note = 4'd9;
            8'h31: key_note = 4'd10;
            8'h3B: key_note = 4'd11;
            8'h3A: key_note = 4'd12;
            default: key_note = 4'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (scan_valid) begin
            case (r_state)
                S_IDLE:  if (scan_code == 8'hF0) w_state_next = S_BRK;
                         else if (scan_code == 8'hE0) w_state_next = S_EXT;
                S_BRK:   w_state_next = S_IDLE;
                S_EXT:   w_state_next = (scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_do_make  = 1'b0;
        w_do_break = 1'b0;
        if (scan_valid) begin
            w_do_make  = (r_state == S_IDLE) && (scan_code != 8'hF0) && (scan_code != 8'hE0);
            w_do_break = (r_state == S_BRK);
        end
    end

    assign w_note = key_note(scan_code);
    assign w_idx  = w_note - 4'd1;

`ifdef KB_OCT_WRAP_EN
    assign w_oct_up = (octave == OCT_MAX) ? 3'd0 : octave + 3'd1;
    assign w_oct_dn = (octave == 3'd0) ? OCT_MAX : octave - 3'd1;
`else
    assign w_oct_up = (octave == OCT_MAX) ? OCT_MAX : octave + 3'd1;
    assign w_oct_dn = (octave == 3'd0) ? 3'd0 : octave - 3'd1;
`endif

    // Key state and event staging; the staged event reaches the FIFO one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_mask   <= 12'd0;
            octave      <= OCT_RESET;
            r_push      <= 1'b0;
            r_push_data <= 8'd0;
            for (int i = 0; i < 12; i++) r_note_oct[i] <= 3'd0;
        end else begin
            r_push <= 1'b0;
            if (w_do_make) begin
                if (w_note != 4'd0) begin
                    if (!held_mask[w_idx]) begin
                        held_mask[w_idx]  <= 1'b1;
                        r_note_oct[w_idx] <= octave;
                        r_push            <= 1'b1;
                        r_push_data       <= {w_note, octave, 1'b1};
                    end
                end else if (scan_code == OCT_UP_CODE) begin
                    octave <= w_oct_up;
                end else if (scan_code == OCT_DN_CODE) begin
                    octave <= w_oct_dn;
                end
            end else if (w_do_break && (w_note != 4'd0) && held_mask[w_idx]) begin
                held_mask[w_idx] <= 1'b0;
                r_push           <= 1'b1;
                r_push_data      <= {w_note, r_note_oct[w_idx], 1'b0};
            end
        end
    end

    assign w_pop  = evt_valid && evt_ready;
    assign w_full = (r_count == CW'(EVT_DEPTH));
    assign w_wr   = r_push && (!w_full || w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_pop)      w_count_next = r_count + 1'b1;
        else if (!w_wr && w_pop) w_count_next = r_count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            evt_valid    <= 1'b0;
            evt_overflow <= 1'b0;
            for (int i = 0; i < EVT_DEPTH; i++) r_mem[i] <= 8'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= r_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (r_push && !w_wr) evt_overflow <= 1'b1;
            r_count   <= w_count_next;
            evt_valid <= (w_count_next != '0);
        end
    end

    assign evt_note   = r_mem[r_rd_ptr][7:4];
    assign evt_octave = r_mem[r_rd_ptr][3:1];
    assign evt_on     = r_mem[r_rd_ptr][0];

endmodule

`default_nettype wire

// File: tb/tb_kb_note_sequencer.sv
// Directed self-checking bench for kb_note_sequencer; events are captured at each accepted handshake.
`default_nettype none

module tb_kb_note_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  scan_code = 8'd0;
    logic        scan_valid = 1'b0;
    logic        evt_valid;
    logic        evt_ready = 1'b1;
    logic [3:0]  evt_note;
    logic [2:0]  evt_octave;
    logic        evt_on;
    logic [2:0]  octave;
    logic [11:0] held_mask;
    logic        evt_overflow;

    int checks = 0;
    int failures = 0;
    logic [7:0] q [$];

    kb_note_sequencer dut (
        .clk(clk), .rst(rst), .scan_code(scan_code), .scan_valid(scan_valid),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_note(evt_note),
        .evt_octave(evt_octave), .evt_on(evt_on), .octave(octave),
        .held_mask(held_mask), .evt_overflow(evt_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && evt_valid && evt_ready) q.push_back({evt_note, evt_octave, evt_on});

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; scan_valid = 1'b0; evt_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code = b; scan_valid = 1'b1;
        @(posedge clk); #1;
        scan_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({evt_valid, evt_note, evt_octave, evt_on} !== 9'd0) begin
            $display("FAIL reset_evt got=%h exp=0", {evt_valid, evt_note, evt_octave, evt_on}); failures++;
        end
        checks++;
        if ({octave, held_mask, evt_overflow} !== {3'd4, 12'd0, 1'b0}) begin
            $display("FAIL reset_state got oct=%0d held=%h ovf=%b exp oct=4 held=000 ovf=0",
                     octave, held_mask, evt_overflow); failures++;
        end
    endtask

    task automatic test_make_break();
        do_reset();
        send_byte(8'h1A);
        checks++;
        if (held_mask !== 12'h001 || evt_valid !== 1'b0) begin
            $display("FAIL latency_1 got held=%h valid=%b exp held=001 valid=0", held_mask, evt_valid); failures++;
        end
        idle(1);
        checks++;
        if ({evt_valid, evt_note, evt_octave, evt_on} !== {1'b1, 4'd1, 3'd4, 1'b1}) begin
            $display("FAIL latency_2 got v=%b n=%0d o=%0d on=%b exp v=1 n=1 o=4 on=1",
                     evt_valid, evt_note, evt_octave, evt_on); failures++;
        end
        send_byte(8'hF0); send_byte(8'h1A); idle(4);
        checks++;
        if (q.size() != 2 || q[0] !== {4'd1, 3'd4, 1'b1} || q[1] !== {4'd1, 3'd4, 1'b0} || held_mask !== 12'h000) begin
            $display("FAIL make_break got n=%0d held=%h exp 2 events held=000", q.size(), held_mask); failures++;
        end
    endtask

    task automatic test_typematic();
        do_reset();
        send_byte(8'h3A); send_byte(8'h3A); send_byte(8'h3A);
        send_byte(8'hF0); send_byte(8'h3A); idle(4);
        checks++;
        if (q.size() != 2 || q[0] !== {4'd12, 3'd4, 1'b1} || q[1] !== {4'd12, 3'd4, 1'b0}) begin
            $display("FAIL typematic got count=%0d first=%h exp count=2 first=%h", q.size(),
                     (q.size() > 0) ? q[0] : 8'hxx, {4'd12, 3'd4, 1'b1}); failures++;
        end
    endtask

    task automatic test_octave_release();
        do_reset();
        send_byte(8'h21); send_byte(8'h55); send_byte(8'h55);
        checks++;
        if (octave !== 3'd6) begin
            $display("FAIL octave_up got=%0d exp=6", octave); failures++;
        end
        send_byte(8'hF0); send_byte(8'h21); send_byte(8'h21); idle(4);
        checks++;
        if (q.size() != 3 || q[1] !== {4'd5, 3'd4, 1'b0} || q[2] !== {4'd5, 3'd6, 1'b1}) begin
            $display("FAIL release_octave got count=%0d rel=%h exp count=3 rel=%h", q.size(),
                     (q.size() > 1) ? q[1] : 8'hxx, {4'd5, 3'd4, 1'b0}); failures++;
        end
    endtask

    task automatic test_octave_limits();
        logic [2:0] exp_hi, exp_lo;
`ifdef KB_OCT_WRAP_EN
        exp_hi = 3'd5; exp_lo = 3'd4;
`else
        exp_hi = 3'd7; exp_lo = 3'd0;
`endif
        do_reset();
        repeat (9) send_byte(8'h55);
        checks++;
        if (octave !== exp_hi) begin
            $display("FAIL octave_top got=%0d exp=%0d", octave, exp_hi); failures++;
        end
        send_byte(8'hF0); send_byte(8'h55);
        repeat (9) send_byte(8'h4E);
        idle(2);
        checks++;
        if (octave !== exp_lo || q.size() != 0) begin
            $display("FAIL octave_bottom got=%0d events=%0d exp=%0d events=0", octave, q.size(), exp_lo); failures++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        evt_ready = 1'b0;
        send_byte(8'h1A); send_byte(8'h1B); send_byte(8'h22);
        send_byte(8'h23); send_byte(8'h21); send_byte(8'h2B);
        idle(3);
        checks++;
        if (evt_overflow !== 1'b1 || held_mask !== 12'h03F) begin
            $display("FAIL overflow got ovf=%b held=%h exp ovf=1 held=03f", evt_overflow, held_mask); failures++;
        end
        checks++;
        if ({evt_valid, evt_note, evt_octave, evt_on} !== {1'b1, 4'd1, 3'd4, 1'b1}) begin
            $display("FAIL stall_head got v=%b n=%0d o=%0d on=%b exp v=1 n=1 o=4 on=1",
                     evt_valid, evt_note, evt_octave, evt_on); failures++;
        end
        @(negedge clk); evt_ready = 1'b1;
        idle(8);
        checks++;
        if (q.size() != 4 || q[0] !== {4'd1, 3'd4, 1'b1} || q[1] !== {4'd2, 3'd4, 1'b1} ||
            q[2] !== {4'd3, 3'd4, 1'b1} || q[3] !== {4'd4, 3'd4, 1'b1} || evt_valid !== 1'b0) begin
            $display("FAIL drain_order got count=%0d valid=%b exp count=4 valid=0", q.size(), evt_valid); failures++;
        end
        checks++;
        if (evt_overflow !== 1'b1) begin
            $display("FAIL overflow_sticky got=%b exp=1", evt_overflow); failures++;
        end
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'h1B); idle(3);
        q.delete();
        send_byte(8'hE0); send_byte(8'h1A);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h1B);
        idle(4);
        checks++;
        if (q.size() != 0 || held_mask !== 12'h002) begin
            $display("FAIL extended got events=%0d held=%h exp events=0 held=002", q.size(), held_mask); failures++;
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        send_byte(8'hF0);
        @(negedge clk); rst = 1'b1;
        #2; rst = 1'b0;
        q.delete();
        send_byte(8'h1A); idle(4);
        checks++;
        if (q.size() != 1 || q[0] !== {4'd1, 3'd4, 1'b1} || held_mask !== 12'h001) begin
            $display("FAIL reset_midstream got events=%0d held=%h exp events=1 held=001", q.size(), held_mask); failures++;
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_typematic();
        test_octave_release();
        test_octave_limits();
        test_overflow();
        test_extended();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
